// File: rtl/mask_index_encoder.sv
// mask_index_encoder: serially emits the index of every set bit of an accepted mask, lowest first.
// Optional out_remaining popcount port is enabled by defining MASK_INDEX_ENCODER_CNT_EN.
module mask_index_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_mask
`ifdef MASK_INDEX_ENCODER_CNT_EN
  ,
  output logic [IDX_W:0]   out_remaining
`endif
);

  // state | meaning
  // IDLE  | waiting for a mask, in_ready high
  // BUSY  | presenting lowest remaining set bit of mask_q
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  generate
    if (WIDTH < 2) begin : g_width_chk
      $error("mask_index_encoder: WIDTH must be >= 2");
    end
    if (IDX_W != $clog2(WIDTH)) begin : g_idx_chk
      $error("mask_index_encoder: IDX_W must equal $clog2(WIDTH)");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             zero_q, zero_d;
  logic [IDX_W-1:0] idx_lo;
  logic [WIDTH-1:0] mask_cleared;
  logic             one_bit;
  logic             in_fire;
  logic             out_fire;

  // Scan downward so the lowest set bit wins; an empty mask yields index 0.
  always_comb begin
    idx_lo = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_q[i]) idx_lo = IDX_W'(i);
    end
  end

  assign mask_cleared = mask_q & (mask_q - WIDTH'(1));
  assign one_bit      = (mask_q != '0) && (mask_cleared == '0);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == BUSY);
  assign out_idx   = idx_lo;
  assign out_last  = (state_q == BUSY) && one_bit;
  assign zero_mask = zero_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (in_data == '0) begin
            zero_d = 1'b1;
          end else begin
            mask_d  = in_data;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (out_fire) begin
          mask_d = mask_cleared;
          if (one_bit) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      zero_q  <= zero_d;
    end
  end

`ifdef MASK_INDEX_ENCODER_CNT_EN
  // mask_q is cleared in IDLE, so the popcount is naturally 0 there.
  always_comb begin
    out_remaining = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_remaining = out_remaining + (IDX_W + 1)'(mask_q[i]);
    end
  end
`endif

endmodule

// File: tb/tb_mask_index_encoder.sv
// Directed self-checking bench for mask_index_encoder (WIDTH=8): vector table plus corner sequences.
module tb_mask_index_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_idx;
  logic       out_last;
  logic       zero_mask;
`ifdef MASK_INDEX_ENCODER_CNT_EN
  logic [3:0] out_remaining;
`endif

  int tests = 0;
  int fails = 0;

  mask_index_encoder #(.WIDTH(8), .IDX_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx(out_idx),
    .out_last(out_last),
    .zero_mask(zero_mask)
`ifdef MASK_INDEX_ENCODER_CNT_EN
    ,
    .out_remaining(out_remaining)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] mask;
    int         hold;      // cycles of out_ready=0 before the first beat
    int         n_beats;   // hand-computed popcount
    int         first_idx;
    int         last_idx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{mask: 8'b1010_0100, hold: 0, n_beats: 3, first_idx: 2, last_idx: 7};
    vecs[1] = '{mask: 8'b0000_0011, hold: 3, n_beats: 2, first_idx: 0, last_idx: 1};
    vecs[2] = '{mask: 8'h00,        hold: 0, n_beats: 0, first_idx: 0, last_idx: 0};
    vecs[3] = '{mask: 8'h80,        hold: 0, n_beats: 1, first_idx: 7, last_idx: 7};
    vecs[4] = '{mask: 8'h01,        hold: 2, n_beats: 1, first_idx: 0, last_idx: 0};
    vecs[5] = '{mask: 8'b0101_1010, hold: 1, n_beats: 4, first_idx: 1, last_idx: 6};

    // Reset held for two cycles, then idle state checks
    step();
    step();
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_zero_mask", 32'(zero_mask), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef MASK_INDEX_ENCODER_CNT_EN
    check("rst_remaining", 32'(out_remaining), 32'd0);
`endif

    foreach (vecs[v]) begin
      int beats;
      int first_seen;
      int last_seen;
      int prev;
      beats = 0;
      first_seen = -1;
      last_seen = -1;
      prev = -1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = vecs[v].mask;
      check("vec_in_ready_pre", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_data = 8'h00;
      if (vecs[v].n_beats == 0) begin
        check("vec_zero_pulse", 32'(zero_mask), 32'd1);
        check("vec_zero_no_out", 32'(out_valid), 32'd0);
        check("vec_zero_ready", 32'(in_ready), 32'd1);
        step();
        check("vec_zero_pulse_end", 32'(zero_mask), 32'd0);
        check("vec_zero_no_out2", 32'(out_valid), 32'd0);
      end else begin
        out_ready = 1'b0;
        for (int h = 0; h < vecs[v].hold; h++) begin
          check("bp_valid_held", 32'(out_valid), 32'd1);
          check("bp_idx_held", 32'(out_idx), 32'(vecs[v].first_idx));
          step();
        end
        out_ready = 1'b1;
        // Bounded walk over beats; model tracks first/last index and count
        for (int c = 0; c < 10 && out_valid === 1'b1; c++) begin
          check("beat_in_ready", 32'(in_ready), 32'd0);
          if (prev >= 0) check("beat_ascending", 32'(int'(out_idx) > prev), 32'd1);
          check("beat_idx_in_mask", 32'(vecs[v].mask[out_idx]), 32'd1);
          check("beat_last_flag", 32'(out_last), 32'(int'(out_idx) == vecs[v].last_idx));
`ifdef MASK_INDEX_ENCODER_CNT_EN
          check("beat_remaining", 32'(out_remaining), 32'(vecs[v].n_beats - beats));
`endif
          if (first_seen < 0) first_seen = int'(out_idx);
          last_seen = int'(out_idx);
          prev = int'(out_idx);
          beats++;
          step();
        end
        check("vec_beat_count", 32'(beats), 32'(vecs[v].n_beats));
        check("vec_first_idx", 32'(first_seen), 32'(vecs[v].first_idx));
        check("vec_last_idx", 32'(last_seen), 32'(vecs[v].last_idx));
        check("vec_ready_back", 32'(in_ready), 32'd1);
        check("vec_zero_quiet", 32'(zero_mask), 32'd0);
      end
    end

    // Full mask while a second request is held through BUSY
    in_valid = 1'b1;
    in_data = 8'hFF;
    step();
    in_data = 8'h81;
    for (int i = 0; i < 8; i++) begin
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_valid", 32'(out_valid), 32'd1);
      check("full_idx", 32'(out_idx), 32'(i));
      check("full_last", 32'(out_last), 32'(i == 7));
      step();
    end
    check("full_done_ready", 32'(in_ready), 32'd1);
    check("full_done_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check("second_idx0", 32'(out_idx), 32'd0);
    check("second_last0", 32'(out_last), 32'd0);
    step();
    check("second_idx7", 32'(out_idx), 32'd7);
    check("second_last7", 32'(out_last), 32'd1);
    step();
    check("second_done", 32'(out_valid), 32'd0);

    // Reset after idx 4 of 8'hF0 is accepted
    in_valid = 1'b1;
    in_data = 8'hF0;
    step();
    in_valid = 1'b0;
    check("mid_idx4", 32'(out_idx), 32'd4);
`ifdef MASK_INDEX_ENCODER_CNT_EN
    check("mid_rem4", 32'(out_remaining), 32'd4);
`endif
    step();
    check("mid_idx5", 32'(out_idx), 32'd5);
`ifdef MASK_INDEX_ENCODER_CNT_EN
    check("mid_rem3", 32'(out_remaining), 32'd3);
`endif
    reset = 1'b1;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_idx", 32'(out_idx), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
`ifdef MASK_INDEX_ENCODER_CNT_EN
    check("mid_rst_rem", 32'(out_remaining), 32'd0);
`endif
    reset = 1'b0;
    step();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
